slow_count_monitor: RTL

//  Slow-domain consumer of the multi-bit event count that crosses from the fast domain.
//  - Resynchronises the raw bus and filters transition glitches with a stability window.
//  - Turns each accepted change into a delta pulse and keeps a wide running total.
//  - Flags skipped or corrupted values with a sticky error.

---
 rtl/count_mon_pkg.sv | 23 ++
 rtl/count_mon_sync.sv | 68 ++++++
 rtl/slow_count_monitor.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/count_mon_pkg.sv
// Shared types and helpers for the slow-domain count monitor.
//   state_t        : FSM encoding (INIT=0, TRACK=1, FAULT=2)
//   STATE_W        : width of the exported state port
//   stab_cnt_width : width needed for a stability counter saturating at n
package count_mon_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // Counter must be able to hold n itself (its saturation value).
    function automatic int unsigned stab_cnt_width(input int unsigned n);
        if (n < 2) begin
            return 1;
        end
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/count_mon_sync.sv
// Two-flop resynchroniser for the raw count bus plus a stability filter.
// A new value is offered once (o_accept_c) after it has been seen stable
// for STABLE_CYCLES consecutive synced samples.
// Ports:
//   clk2       : slow-domain clock
//   reset_n    : async active-low reset
//   i_count    : raw count, asynchronous to clk2
//   o_cand     : synchronised candidate value (second sync flop)
//   o_accept_c : one-shot accept strobe for o_cand (combinational)
module count_mon_sync
    import count_mon_pkg::*;
#(
    parameter int unsigned W             = 4,
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic         clk2,
    input  logic         reset_n,
    input  logic [W-1:0] i_count,
    output logic [W-1:0] o_cand,
    output logic         o_accept_c
);

    localparam int unsigned   CW       = stab_cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] STAB_SAT = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] STAB_HIT = CW'(STABLE_CYCLES - 1);

    logic [W-1:0]  r_s1;
    logic [W-1:0]  r_s2;
    logic [W-1:0]  r_prev;
    logic [CW-1:0] r_stab_cnt;
    logic          r_armed;
    logic          w_changed;

    assign w_changed = (r_s2 != r_prev);

    // r_armed makes acceptance one-shot per observed change; it also keeps
    // the post-reset bus value from being mistaken for a fresh count.
    assign o_accept_c = r_armed && (r_stab_cnt == STAB_HIT);
    assign o_cand     = r_s2;

    // Sync chain, stability counter and arm flag.
    always_ff @(posedge clk2 or negedge reset_n) begin
        if (!reset_n) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_prev     <= '0;
            r_stab_cnt <= '0;
            r_armed    <= 1'b0;
        end else begin
            r_s1   <= i_count;
            r_s2   <= r_s1;
            r_prev <= r_s2;

            if (w_changed) begin
                r_stab_cnt <= '0;
            end else if (r_stab_cnt != STAB_SAT) begin
                r_stab_cnt <= r_stab_cnt + CW'(1);
            end

            if (w_changed) begin
                r_armed <= 1'b1;
            end else if (o_accept_c) begin
                r_armed <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/slow_count_monitor.sv
// Slow-domain consumer of a multi-bit event count crossing from a fast
// domain. Filters the synchronised bus, emits a delta pulse per legal
// step, keeps a saturating running total and flags skipped values.
// Optional feature macro: COUNT_MON_ERRCNT_EN adds the err_count port,
// a saturating count of TRACK->FAULT transitions.
// Ports:
//   clk2      : slow-domain clock
//   reset_n   : async active-low reset
//   count_in  : raw count from the fast domain (wraps mod 2^W)
//   clear_err : pulse; clears sticky err and returns FAULT to TRACK
//   upd_valid : one-cycle pulse per legal accepted step
//   upd_value : last accepted value (baseline)
//   upd_delta : delta of the most recent legal step, held
//   total     : saturating sum of legal deltas
//   err       : sticky skip/corruption flag
//   state     : FSM state (INIT=0, TRACK=1, FAULT=2)
//   err_count : saturating fault counter (COUNT_MON_ERRCNT_EN only)
module slow_count_monitor
    import count_mon_pkg::*;
#(
    parameter int unsigned W             = 4,
    parameter int unsigned TW            = 16,
    parameter int unsigned STABLE_CYCLES = 2,
    parameter int unsigned MAX_STEP      = 1
) (
    input  logic               clk2,
    input  logic               reset_n,
    input  logic [W-1:0]       count_in,
    input  logic               clear_err,
    output logic               upd_valid,
    output logic [W-1:0]       upd_value,
    output logic [W-1:0]       upd_delta,
    output logic [TW-1:0]      total,
    output logic               err,
    output logic [STATE_W-1:0] state
`ifdef COUNT_MON_ERRCNT_EN
    ,
    output logic [7:0]         err_count
`endif
);

    localparam int unsigned  SW         = TW + 1;
    localparam logic [W-1:0] MAX_STEP_W = W'(MAX_STEP);

    logic [W-1:0]  w_cand;
    logic          w_accept_c;

    state_t        r_state;
    logic          r_upd_valid;
    logic [W-1:0]  r_upd_value;
    logic [W-1:0]  r_upd_delta;
    logic [TW-1:0] r_total;
    logic          r_err;

    state_t        w_state_nxt;
    logic          w_valid_nxt;
    logic [W-1:0]  w_value_nxt;
    logic [W-1:0]  w_delta_nxt;
    logic [TW-1:0] w_total_nxt;
    logic          w_err_nxt;

    logic          w_new_val;
    logic [W-1:0]  w_diff;
    logic          w_step_ok;
    logic [SW-1:0] w_sum;
    logic [TW-1:0] w_total_sat;

    // Resynchronise and filter the raw bus.
    count_mon_sync #(
        .W             (W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_sync (
        .clk2       (clk2),
        .reset_n    (reset_n),
        .i_count    (count_in),
        .o_cand     (w_cand),
        .o_accept_c (w_accept_c)
    );

    // Modular distance from the baseline; wrap 2^W-1 -> 0 is a step of 1.
    assign w_new_val   = w_accept_c && (w_cand != r_upd_value);
    assign w_diff      = w_cand - r_upd_value;
    assign w_step_ok   = (w_diff <= MAX_STEP_W);
    assign w_sum       = SW'(r_total) + SW'(w_diff);
    assign w_total_sat = w_sum[TW] ? '1 : w_sum[TW-1:0];

    // State and output registers.
    always_ff @(posedge clk2 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_INIT;
            r_upd_valid <= 1'b0;
            r_upd_value <= '0;
            r_upd_delta <= '0;
            r_total     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_upd_valid <= w_valid_nxt;
            r_upd_value <= w_value_nxt;
            r_upd_delta <= w_delta_nxt;
            r_total     <= w_total_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = 1'b0;
        w_value_nxt = r_upd_value;
        w_delta_nxt = r_upd_delta;
        w_total_nxt = r_total;
        w_err_nxt   = r_err;

        unique case (r_state)
            ST_INIT: begin
                if (w_new_val) begin
                    w_value_nxt = w_cand;
                    w_state_nxt = ST_TRACK;
                end
            end

            // clear_err is ignored here, so a fault in the same cycle wins.
            ST_TRACK: begin
                if (w_new_val) begin
                    w_value_nxt = w_cand;
                    if (w_step_ok) begin
                        w_valid_nxt = 1'b1;
                        w_delta_nxt = w_diff;
                        w_total_nxt = w_total_sat;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_FAULT;
                    end
                end
            end

            // Baseline follows silently until software acknowledges.
            ST_FAULT: begin
                if (w_new_val) begin
                    w_value_nxt = w_cand;
                end
                if (clear_err) begin
                    w_err_nxt   = 1'b0;
                    w_state_nxt = ST_TRACK;
                end
            end

            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    assign upd_valid = r_upd_valid;
    assign upd_value = r_upd_value;
    assign upd_delta = r_upd_delta;
    assign total     = r_total;
    assign err       = r_err;
    assign state     = r_state;

`ifdef COUNT_MON_ERRCNT_EN
    logic [7:0] r_err_count;

    // Counts TRACK->FAULT entries; survives clear_err.
    always_ff @(posedge clk2 or negedge reset_n) begin
        if (!reset_n) begin
            r_err_count <= '0;
        end else if ((r_state == ST_TRACK) && (w_state_nxt == ST_FAULT) &&
                     (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule
